// File: rtl/pipe_pkg.sv
// Shared ID/EX definitions: opcodes, ALU op classes, funct codes and the control bundle.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic [1:0] aluop;
        logic [5:0] sel;
        logic       alusrc;
        logic       regdst;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_ctrl_main_decoder.sv
// Combinational opcode decoder: control bundle, legal flag, and whether rt is a source.
// Optional macro SLTI_EN adds slti decoding through the ALU set-less-than path.
module main_decoder
    import pipe_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       legal,
    output logic       uses_rt
);

    always_comb begin
        ctrl    = CTRL_NOP;
        legal   = 1'b1;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.aluop    = ALUOP_FUNCT;
                ctrl.sel      = funct;
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                ctrl.aluop    = ALUOP_ADD;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_SW: begin
                ctrl.aluop    = ALUOP_ADD;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.aluop  = ALUOP_SUB;
                ctrl.branch = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.aluop    = ALUOP_IMM;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
`ifdef SLTI_EN
            OP_SLTI: begin
                ctrl.aluop    = ALUOP_FUNCT;
                ctrl.sel      = FN_SLT;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID stage control: decode, load-use hazard stall, branch flush and the ID/EX register.
// Optional macro SLTI_EN (handled in main_decoder) enables slti.
module id_ex_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              ifid_valid,
    input  logic              flush,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [1:0]        ex_aluOP,
    output logic [5:0]        ex_sel,
    output logic              ex_aluSrc,
    output logic              ex_regDst,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic              ex_memToReg,
    output logic              ex_regWrite,
    output logic              ex_branch,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_valid,
    output logic              illegal
);

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    ctrl_t             dec_ctrl;
    ctrl_t             ctrl_q;
    logic              dec_legal;
    logic              dec_uses_rt;
    logic              hazard;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;

    assign id_rs = instr[25 -: REG_AW];
    assign id_rt = instr[20 -: REG_AW];
    assign id_rd = instr[15 -: REG_AW];

    main_decoder u_dec (
        .opcode  (instr[31:26]),
        .funct   (instr[5:0]),
        .ctrl    (dec_ctrl),
        .legal   (dec_legal),
        .uses_rt (dec_uses_rt)
    );

    // A load in EX whose destination feeds the ID instruction must wait one cycle.
    assign hazard = ifid_valid && ex_valid && ctrl_q.memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (dec_uses_rt && (ex_rt == id_rt)));

    assign pc_write   = flush || !hazard;
    assign ifid_write = flush || !hazard;

    // ID -> EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= CTRL_NOP;
            ex_valid <= 1'b0;
            illegal  <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_imm   <= '0;
        end else begin
            ex_rs  <= id_rs;
            ex_rt  <= id_rt;
            ex_rd  <= id_rd;
            ex_imm <= sext16(instr[15:0]);
            if (flush || hazard) begin
                ctrl_q   <= CTRL_NOP;
                ex_valid <= 1'b0;
                illegal  <= 1'b0;
            end else begin
                ctrl_q   <= (ifid_valid && dec_legal) ? dec_ctrl : CTRL_NOP;
                ex_valid <= ifid_valid && dec_legal;
                illegal  <= ifid_valid && !dec_legal;
            end
        end
    end

    assign ex_aluOP    = ctrl_q.aluop;
    assign ex_sel      = ctrl_q.sel;
    assign ex_aluSrc   = ctrl_q.alusrc;
    assign ex_regDst   = ctrl_q.regdst;
    assign ex_memRead  = ctrl_q.memread;
    assign ex_memWrite = ctrl_q.memwrite;
    assign ex_memToReg = ctrl_q.memtoreg;
    assign ex_regWrite = ctrl_q.regwrite;
    assign ex_branch   = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Directed bench for id_ex_ctrl: decode vector table plus stall, flush and async-reset sequences.
module tb_id_ex_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        ifid_valid;
    logic        flush;
    logic        pc_write, ifid_write;
    logic [1:0]  ex_aluOP;
    logic [5:0]  ex_sel;
    logic        ex_aluSrc, ex_regDst, ex_memRead, ex_memWrite, ex_memToReg;
    logic        ex_regWrite, ex_branch, ex_valid, illegal;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_imm;

    int checks = 0;
    int errors = 0;

    id_ex_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .ifid_valid(ifid_valid), .flush(flush),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ex_aluOP(ex_aluOP), .ex_sel(ex_sel), .ex_aluSrc(ex_aluSrc), .ex_regDst(ex_regDst),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
        .ex_regWrite(ex_regWrite), .ex_branch(ex_branch),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .ex_valid(ex_valid), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {aluOP, sel, aluSrc, regDst, memRead, memWrite, memToReg, regWrite, branch, ex_valid, illegal}
    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic        f;
        logic [16:0] ctl;
        logic        chk_fields;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    function automatic logic [16:0] got_ctl();
        return {ex_aluOP, ex_sel, ex_aluSrc, ex_regDst, ex_memRead, ex_memWrite,
                ex_memToReg, ex_regWrite, ex_branch, ex_valid, illegal};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic f);
        instr = i;
        ifid_valid = v;
        flush = f;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'h00221820, 1'b1, 1'b0, {2'b10, 6'b100000, 7'b0100010, 2'b10}, 1'b1, 5'd3,  32'h00001820};
        vecs[1]  = '{32'h8C220004, 1'b1, 1'b0, {2'b00, 6'b000000, 7'b1010110, 2'b10}, 1'b1, 5'd0,  32'h00000004};
        vecs[2]  = '{32'h2001FFFF, 1'b1, 1'b0, {2'b11, 6'b000000, 7'b1000010, 2'b10}, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[3]  = '{32'h10220003, 1'b1, 1'b0, {2'b01, 6'b000000, 7'b0000001, 2'b10}, 1'b1, 5'd0,  32'h00000003};
        vecs[4]  = '{32'hAC220008, 1'b1, 1'b0, {2'b00, 6'b000000, 7'b1001000, 2'b10}, 1'b1, 5'd0,  32'h00000008};
        vecs[5]  = '{32'h00221822, 1'b1, 1'b0, {2'b10, 6'b100010, 7'b0100010, 2'b10}, 1'b1, 5'd3,  32'h00001822};
        vecs[6]  = '{32'h00221820, 1'b0, 1'b0, 17'b0, 1'b0, 5'd0, 32'h0};
        vecs[7]  = '{32'hFC000000, 1'b1, 1'b0, {15'b0, 2'b01}, 1'b0, 5'd0, 32'h0};
`ifdef SLTI_EN
        vecs[8]  = '{32'h2822000A, 1'b1, 1'b0, {2'b10, 6'b101010, 7'b1000010, 2'b10}, 1'b1, 5'd0, 32'h0000000A};
`else
        vecs[8]  = '{32'h2822000A, 1'b1, 1'b0, {15'b0, 2'b01}, 1'b1, 5'd0, 32'h0000000A};
`endif
        vecs[9]  = '{32'h00221820, 1'b1, 1'b1, 17'b0, 1'b0, 5'd0, 32'h0};
        vecs[10] = '{32'h00221824, 1'b1, 1'b0, {2'b10, 6'b100100, 7'b0100010, 2'b10}, 1'b1, 5'd3, 32'h00001824};

        // Reset state
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_ctl", 64'(got_ctl()), 64'd0);
        check("reset_imm_rd", {27'b0, ex_rd, ex_imm}, 64'd0);
        check("reset_pc_write", {62'b0, pc_write, ifid_write}, 64'd3);
        rst = 1'b0;

        // Decode table
        foreach (vecs[k]) begin
            drive(vecs[k].instr, vecs[k].v, vecs[k].f);
            #1;
            check($sformatf("vec%0d_pc_write", k), {62'b0, pc_write, ifid_write}, 64'd3);
            @(negedge clk);
            check($sformatf("vec%0d_ctl", k), 64'(got_ctl()), 64'(vecs[k].ctl));
            if (vecs[k].chk_fields) begin
                check($sformatf("vec%0d_rd", k), 64'(ex_rd), 64'(vecs[k].rd));
                check($sformatf("vec%0d_imm", k), 64'(ex_imm), 64'(vecs[k].imm));
            end
        end

        // Load-use: lw $2,4($1) then add $3,$2,$2 costs one stall
        drive(32'h8C220004, 1'b1, 1'b0);
        @(negedge clk);
        check("lu_lw_in_ex", {63'b0, ex_memRead}, 64'd1);
        drive(32'h00421820, 1'b1, 1'b0);
        #1;
        check("lu_stall", {62'b0, pc_write, ifid_write}, 64'd0);
        @(negedge clk);
        check("lu_bubble_valid", {63'b0, ex_valid}, 64'd0);
        check("lu_stall_released", {62'b0, pc_write, ifid_write}, 64'd3);
        @(negedge clk);
        check("lu_add_in_ex", {54'b0, ex_valid, ex_aluOP, ex_rd}, {54'b0, 1'b1, 2'b10, 5'd3});
        check("lu_add_sel", 64'(ex_sel), 64'h20);

        // Flush beats the hazard
        drive(32'h8C220004, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h00421820, 1'b1, 1'b1);
        #1;
        check("fl_no_stall", {62'b0, pc_write, ifid_write}, 64'd3);
        @(negedge clk);
        check("fl_bubble", 64'(got_ctl()), 64'd0);
        drive(32'h00421820, 1'b1, 1'b0);
        #1;
        check("fl_after_pc_write", {62'b0, pc_write, ifid_write}, 64'd3);
        @(negedge clk);
        check("fl_add_in_ex", {63'b0, ex_valid}, 64'd1);

        // Hazard boundaries: rt==0 load, rt-only match on addi, sw rt match, ifid invalid
        drive(32'h8C200004, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h00001820, 1'b1, 1'b0);
        #1;
        check("hz_rt_zero", {63'b0, pc_write}, 64'd1);
        drive(32'h8C220004, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h20020005, 1'b1, 1'b0);
        #1;
        check("hz_addi_rt_only", {63'b0, pc_write}, 64'd1);
        drive(32'h8C220004, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'hAC020008, 1'b1, 1'b0);
        #1;
        check("hz_sw_rt", {62'b0, pc_write, ifid_write}, 64'd0);
        drive(32'h00421820, 1'b0, 1'b0);
        #1;
        check("hz_ifid_invalid", {62'b0, pc_write, ifid_write}, 64'd3);
        @(negedge clk);

        // Async reset mid-stall
        drive(32'h8C220004, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h00421820, 1'b1, 1'b0);
        #1;
        check("ar_stalled", {63'b0, pc_write}, 64'd0);
        #1;
        rst = 1'b1;
        #1;
        check("ar_ctl_cleared", 64'(got_ctl()), 64'd0);
        check("ar_fields_cleared", {22'b0, ex_rs, ex_rt, ex_imm}, 64'd0);
        check("ar_stall_dropped", {62'b0, pc_write, ifid_write}, 64'd3);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl.md
Name: id_ex_ctrl

Overview:
- Decode stage of the pipelined MIPS core: turns the IF/ID instruction into the control bundle the EX-stage ALU consumes (aluOP, sel/funct, operand select).
- Registers that bundle into the ID/EX pipeline register.
- Detects load-use hazards: inserts a bubble and holds the front end.
- Takes the branch-taken flush from EX/MEM.

Parameters:
- DATA_W, 32, instruction/immediate width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- instr  in  32  IF/ID instruction
- ifid_valid  in  1  IF/ID holds a real instruction
- flush  in  1  branch taken in EX/MEM; squash ID
- pc_write  out  1  PC update enable (combinational)
- ifid_write  out  1  IF/ID update enable (combinational)
- ex_aluOP  out  2  ALU op class for EX
- ex_sel  out  6  funct field for EX ALU
- ex_aluSrc  out  1  1 = immediate operand B
- ex_regDst  out  1  1 = rd, 0 = rt destination
- ex_memRead  out  1  load
- ex_memWrite  out  1  store
- ex_memToReg  out  1  writeback from memory
- ex_regWrite  out  1  register-file write
- ex_branch  out  1  beq
- ex_rs / ex_rt / ex_rd  out  5 each  register indices
- ex_imm  out  32  sign-extended instr[15:0]
- ex_valid  out  1  ID/EX holds a real instruction
- illegal  out  1  one-cycle pulse: unknown opcode decoded

Behaviour:
- Reset:
  - Asynchronous, active-high: rst asserts state immediately, independent of clk.
  - All ex_* outputs and illegal = 0.
  - pc_write = ifid_write = 1 once rst deasserts.
- Decode (combinational on instr[31:26]; all other controls 0):
  - 000000 R-type: aluOP=10, sel=instr[5:0], regDst=1, regWrite=1.
  - 100011 lw: aluOP=00, aluSrc=1, memRead=1, memToReg=1, regWrite=1.
  - 101011 sw: aluOP=00, aluSrc=1, memWrite=1.
  - 000100 beq: aluOP=01, branch=1.
  - 001000 addi: aluOP=11, aluSrc=1, regWrite=1.
  - For non-R-type opcodes, sel = 000000.
  - Any other opcode with ifid_valid=1: all controls 0, ex_valid=0, illegal pulses on the next edge.
- Hazard (combinational):
  - Raised when ex_valid && ex_memRead && ex_rt != 0 && (ex_rt == instr[25:21], or ex_rt == instr[20:16] for R-type/sw/beq).
  - Qualified by ifid_valid.
- Register update on every rising clk; exactly one case applies, in this priority order:
  1. flush=1: bubble loaded (all controls 0, ex_valid=0); pc_write=1, ifid_write=1. Flush beats hazard.
  2. hazard=1: bubble loaded; pc_write=0, ifid_write=0. The held instruction re-decodes next cycle and the hazard clears, so a lw followed by a dependent instruction costs exactly one stall cycle.
  3. Otherwise: decoded bundle loaded; ex_valid = ifid_valid and opcode legal; ex_rs/rt/rd/imm always loaded from instr fields.
- Latency: 1 cycle, ID to EX.
- ifid_valid=0: bubble loaded, no illegal pulse.
- Reset mid-stall: pipeline state cleared; stall drops at once.

Optional Feature:
- Macro: SLTI_EN.
- Defined: opcode 001010 (slti) decodes to aluOP=10, sel=101010, aluSrc=1, regWrite=1, regDst=0. This routes slti through the ALU's set-less-than path.
- Undefined: 001010 is illegal, handled as above.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI;
  - aluOP constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_IMM=11;
  - funct constants: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT;
  - the ID/EX control-bundle struct.
- Sub-module main_decoder: purely combinational opcode → control bundle plus legal flag. id_ex_ctrl instantiates it and adds the hazard logic and the register.

Test Plan:
- Reset and R-type: rst pulse, then instr=0x00221820 (add $3,$1,$2) → next cycle ex_aluOP=10, ex_sel=100000, ex_regDst=1, ex_regWrite=1, ex_rd=3, ex_valid=1.
- Load-use stall: lw $2,4($1) (0x8C220004) then add $3,$2,$2 → one cycle pc_write=ifid_write=0 and ex_valid=0; next cycle add appears in EX, pc_write=1.
- Flush over stall: hazard present with flush=1 in the same cycle → bubble loaded, pc_write=1, ifid_write=1, no stall cycle.
- Immediate sign-extend: addi $1,$0,-1 (0x2001FFFF) → ex_aluOP=11, ex_aluSrc=1, ex_imm=0xFFFFFFFF. beq (0x10220003) → ex_aluOP=01, ex_branch=1, ex_regWrite=0.
- slti (0x2822000A), macro-dependent:
  - with SLTI_EN: ex_aluOP=10, ex_sel=101010, ex_aluSrc=1;
  - without SLTI_EN: illegal pulses 1 cycle, ex_valid=0.
- Async reset: assert rst between clock edges mid-stall → all ex_* = 0 immediately, pc_write=1.
